// File: rtl/h264_tx_pkg.sv
// Shared constants and types for the H.264 forward 4x4 core transform.
//   IN_W  : residual sample width (signed)
//   MID_W : row-pass intermediate width (signed)
//   OUT_W : coefficient width (signed)
//   state_t        : control FSM states
//   res_t/mid_t/coef_t : 16-entry packed arrays, index = 4*row + col
package h264_tx_pkg;

    localparam int IN_W  = 8;
    localparam int MID_W = 11;
    localparam int OUT_W = 14;

    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

    typedef logic [15:0][IN_W-1:0]  res_t;
    typedef logic [15:0][MID_W-1:0] mid_t;
    typedef logic [15:0][OUT_W-1:0] coef_t;

endpackage

// File: rtl/fwd_core1d.sv
// Combinational 4-point H.264 forward core butterfly.
//   x0..x3 : signed input vector, W bits
//   y0..y3 : signed transform output, W bits
// W must be wide enough for the output range; no saturation is applied.
module fwd_core1d #(
    parameter int W = 14
) (
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] x3,
    output logic signed [W-1:0] y0,
    output logic signed [W-1:0] y1,
    output logic signed [W-1:0] y2,
    output logic signed [W-1:0] y3
);

    logic signed [W-1:0] e0, e1, e2, e3;

    assign e0 = x0 + x3;
    assign e1 = x1 + x2;
    assign e2 = x1 - x2;
    assign e3 = x0 - x3;

    assign y0 = e0 + e1;
    assign y2 = e0 - e1;
    assign y1 = (e3 <<< 1) + e2;
    assign y3 = e3 - (e2 <<< 1);

endmodule

// File: rtl/fwd_core_transform4x4.sv
// Forward 4x4 integer core transform Y = Cf*X*Cf^T for intra luma residuals.
// One shared 1-D butterfly runs four row passes, then four column passes.
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid/in_ready  : residual block handshake (ready only in IDLE)
//   mode, res       : intra mode and 16 residual samples (4*row+col)
//   out_valid/out_ready: coefficient handshake (valid only in DONE)
//   out_mode, coef, nz : captured mode, 16 coefficients, any-nonzero flag
module fwd_core_transform4x4
    import h264_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  mode,
    input  res_t        res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_mode,
    output coef_t       coef,
    output logic        nz
);

    state_t     state, nxt;
    logic [1:0] k;
    res_t       xbuf;
    mid_t       mbuf;

    logic signed [OUT_W-1:0] cin  [4];
    logic signed [OUT_W-1:0] cout [4];
    logic                    col_nz;

    // Butterfly input mux: row k of X in ROW, column k of the
    // intermediate buffer in COL. Both are sign-extended to OUT_W.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            if (state == COL) cin[j] = OUT_W'($signed(mbuf[{2'(j), k}]));
            else              cin[j] = OUT_W'($signed(xbuf[{k, 2'(j)}]));
        end
    end

    fwd_core1d #(.W(OUT_W)) u_core (
        .x0(cin[0]), .x1(cin[1]), .x2(cin[2]), .x3(cin[3]),
        .y0(cout[0]), .y1(cout[1]), .y2(cout[2]), .y3(cout[3])
    );

    assign col_nz = |{cout[0], cout[1], cout[2], cout[3]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (in_valid)  nxt = ROW;
            ROW:  if (k == 2'd3) nxt = COL;
            COL:  if (k == 2'd3) nxt = DONE;
            DONE: if (out_ready) nxt = IDLE;
            default:             nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath. k wraps 3->0 on the ROW->COL transition, so it needs
    // no explicit clear between passes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k        <= '0;
            xbuf     <= '0;
            mbuf     <= '0;
            coef     <= '0;
            out_mode <= '0;
            nz       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xbuf     <= res;
                    out_mode <= mode;
                    k        <= '0;
                    nz       <= 1'b0;
                end
                ROW: begin
                    // Row results are bounded by 6*128, so truncating to MID_W is lossless.
                    for (int j = 0; j < 4; j++) mbuf[{k, 2'(j)}] <= MID_W'(cout[j]);
                    k <= k + 2'd1;
                end
                COL: begin
                    for (int j = 0; j < 4; j++) coef[{2'(j), k}] <= cout[j];
                    nz <= nz | col_nz;
                    k  <= k + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_core_transform4x4.sv
module tb_fwd_core_transform4x4;
    import h264_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, nz;
    logic [2:0] mode, out_mode;
    res_t       res;
    coef_t      coef;

    int errors = 0;
    int checks = 0;

    fwd_core_transform4x4 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .res(res), .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .coef(coef), .nz(nz)
    );

    always #5 clk = ~clk;

    // Present a block for one cycle; returns on the falling edge after the accept edge.
    task automatic send(input res_t r, input logic [2:0] m);
        @(negedge clk);
        res = r; mode = m; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count falling edges until out_valid (bounded); returns the count.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (coef !== '0 || nz !== 1'b0 || out_mode !== 3'd0) begin
            errors++; $display("FAIL reset_out coef=%h nz=%b mode=%0d want 0", coef, nz, out_mode);
        end
    endtask

    task automatic test_zero();
        res_t r = '0; int cyc;
        send(r, 3'd3);
        wait_out(cyc);
        checks++;
        if (cyc !== 8) begin errors++; $display("FAIL zero_latency got %0d want 8", cyc); end
        checks++;
        if (coef !== '0 || nz !== 1'b0 || out_mode !== 3'd3) begin
            errors++; $display("FAIL zero_out coef=%h nz=%b mode=%0d want 0/0/3", coef, nz, out_mode);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL zero_handshake out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_dc(input logic [IN_W-1:0] v, input int dc, input string nm);
        res_t r; coef_t e = '0; int cyc;
        for (int i = 0; i < 16; i++) r[i] = v;
        e[0] = OUT_W'(dc);
        send(r, 3'd1);
        wait_out(cyc);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (coef[i] !== e[i]) begin
                errors++; $display("FAIL %s coef[%0d] got %0d want %0d", nm, i, $signed(coef[i]), $signed(e[i]));
            end
        end
        checks++;
        if (nz !== 1'b1 || out_mode !== 3'd1) begin
            errors++; $display("FAIL %s_flags nz=%b mode=%0d want 1/1", nm, nz, out_mode);
        end
        @(negedge clk);
    endtask

    task automatic test_impulse();
        res_t r = '0; coef_t e; int cyc;
        int a [4] = '{1, 2, 1, 1};
        r[0] = 8'd1;
        for (int i = 0; i < 16; i++) e[i] = OUT_W'(a[i/4] * a[i%4]);
        send(r, 3'd6);
        wait_out(cyc);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (coef[i] !== e[i]) begin
                errors++; $display("FAIL impulse coef[%0d] got %0d want %0d", i, $signed(coef[i]), $signed(e[i]));
            end
        end
        checks++;
        if (nz !== 1'b1 || out_mode !== 3'd6) begin
            errors++; $display("FAIL impulse_flags nz=%b mode=%0d want 1/6", nz, out_mode);
        end
        @(negedge clk);
    endtask

    function automatic res_t alt_block();
        res_t r;
        for (int i = 0; i < 16; i++) r[i] = (((i / 4) + (i % 4)) % 2 == 0) ? 8'd127 : 8'h81;
        return r;
    endfunction

    function automatic coef_t alt_expect();
        coef_t e = '0;
        e[5] = OUT_W'(508); e[7] = OUT_W'(1524); e[13] = OUT_W'(1524); e[15] = OUT_W'(4572);
        return e;
    endfunction

    task automatic test_alternating();
        coef_t e = alt_expect(); int cyc;
        send(alt_block(), 3'd7);
        wait_out(cyc);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (coef[i] !== e[i]) begin
                errors++; $display("FAIL alt coef[%0d] got %0d want %0d", i, $signed(coef[i]), $signed(e[i]));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        res_t r = '0; coef_t e = '0; res_t ones; int cyc;
        for (int i = 0; i < 16; i++) ones[i] = 8'd1;
        r[0] = 8'd1;
        e[0] = 14'd1; e[1] = 14'd2; e[2] = 14'd1; e[3] = 14'd1;
        e[4] = 14'd2; e[5] = 14'd4; e[6] = 14'd2; e[7] = 14'd2;
        e[8] = 14'd1; e[9] = 14'd2; e[10] = 14'd1; e[11] = 14'd1;
        e[12] = 14'd1; e[13] = 14'd2; e[14] = 14'd1; e[15] = 14'd1;
        out_ready = 1'b0;
        send(r, 3'd2);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_valid); end
        // Hold in DONE while offering another block that must be ignored.
        res = ones; mode = 3'd5; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (coef !== e || out_valid !== 1'b1 || in_ready !== 1'b0 || out_mode !== 3'd2) begin
                errors++; $display("FAIL bp_hold cyc%0d coef=%h valid=%b in_ready=%b mode=%0d", c, coef, out_valid, in_ready, out_mode);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        e = alt_expect();
        send(alt_block(), 3'd4);
        wait_out(cyc);
        checks++;
        if (coef !== e || out_mode !== 3'd4 || nz !== 1'b1) begin
            errors++; $display("FAIL bp_second coef=%h mode=%0d nz=%b", coef, out_mode, nz);
        end
        @(negedge clk);
    endtask

    task automatic test_midreset();
        res_t r; coef_t e = '0; int cyc; logic seen = 1'b0;
        for (int i = 0; i < 16; i++) r[i] = 8'd1;
        send(r, 3'd5);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || coef !== '0 || nz !== 1'b0 || out_mode !== 3'd0) begin
            errors++; $display("FAIL midreset_async valid=%b in_ready=%b coef=%h nz=%b mode=%0d", out_valid, in_ready, coef, nz, out_mode);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_output out_valid seen=%b want 0", seen); end
        for (int i = 0; i < 16; i++) r[i] = 8'h80;
        e[0] = OUT_W'(-2048);
        send(r, 3'd0);
        wait_out(cyc);
        checks++;
        if (cyc !== 8 || coef !== e || out_mode !== 3'd0 || nz !== 1'b1) begin
            errors++; $display("FAIL midreset_fresh cyc=%0d coef=%h mode=%0d nz=%b", cyc, coef, out_mode, nz);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = '0; res = '0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_zero();
        test_dc(8'd1, 16, "ones");
        test_dc(8'h80, -2048, "neg128");
        test_impulse();
        test_alternating();
        test_backpressure();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
